dpram_sched: RTL and testbench

Controller for the team's shared 64x8-write / 32x16-read dual-port RAM. It arbitrates the RAM's single byte-write port between a host writer and a peripheral writer using round-robin arbitration. It also sequences burst read-out of 16-bit words to a downstream consumer over a valid/ready stream, absorbing the RAM's one-cycle synchronous read latency and consumer backpressure. It sits between the host bus decode, the peripheral capture logic and the RAM instance it owns.

---
 rtl/pccore_pkg.sv | 21 ++
 rtl/dpram.sv | 29 ++
 rtl/dpram_sched.sv | 168 ++++++++++++++++
 tb/tb_dpram_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pccore_pkg.sv
// rtl/pccore_pkg.sv - shared widths, read-sequencer states and FIFO entry type
package pccore_pkg;

  // Byte-address width of the write port (64 bytes)
  localparam int WAW = 6;
  // Word-address width of the read port (32 words)
  localparam int RAW = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // One slot of the output buffer: read word plus end-of-burst tag
  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } rd_entry_t;

endpackage

// File: rtl/dpram.sv
// rtl/dpram.sv - 64x8 write / 32x16 read dual-port RAM with registered read
module dpram
  import pccore_pkg::*;
(
  input  logic           clk,
  input  logic           we_i,
  input  logic [WAW-1:0] wa_i,
  input  logic [7:0]     wd_i,
  input  logic           re_i,
  input  logic [RAW-1:0] ra_i,
  output logic [15:0]    rd_o
);

  logic [7:0]  mem_q [0:(1<<WAW)-1];
  logic [15:0] rd_q;

  // Byte write and word read share one edge; a same-edge read sees the old byte
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
    if (re_i) begin
      rd_q <= {mem_q[{ra_i, 1'b1}], mem_q[{ra_i, 1'b0}]};
    end
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/dpram_sched.sv
// rtl/dpram_sched.sv - write-port arbiter and burst read sequencer for dpram
module dpram_sched
  import pccore_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           h_req,
  input  logic [WAW-1:0] h_addr,
  input  logic [7:0]     h_data,
  output logic           h_gnt,
  input  logic           p_req,
  input  logic [WAW-1:0] p_addr,
  input  logic [7:0]     p_data,
  output logic           p_gnt,
  input  logic           rd_start,
  input  logic [RAW-1:0] rd_base,
  input  logic [RAW-1:0] rd_len,
  output logic           rd_busy,
  output logic           rd_valid,
  input  logic           rd_ready,
  output logic [15:0]    rd_data,
  output logic           rd_last
);

  // Burst length used when rd_len is 0
  localparam logic [RAW:0] BURST_MAX = {1'b1, {RAW{1'b0}}};
  localparam logic [RAW:0] REMAIN_ONE = (RAW+1)'(1);

  // Write arbitration
  logic           pri_q, pri_d;
  logic           ram_we;
  logic [WAW-1:0] ram_wa;
  logic [7:0]     ram_wd;

  // Read sequencer
  rd_state_e      state_q, state_d;
  logic [RAW-1:0] addr_q, addr_d;
  logic [RAW:0]   remain_q, remain_d;
  logic           infl_q, infl_last_q;
  logic           issue, issue_last;
  logic [1:0]     occ;
  logic [15:0]    ram_rd;

  // Output buffer
  rd_entry_t      fifo0_q, fifo1_q, head;
  logic           wr_ptr_q, rd_ptr_q;
  logic [1:0]     cnt_q;
  logic           push, pop;

  // Round-robin grant: a lone requester always wins, contention goes to pri and flips it
  always_comb begin
    h_gnt = h_req & (~p_req | ~pri_q);
    p_gnt = p_req & (~h_req | pri_q);
    pri_d = (h_req & p_req) ? ~pri_q : pri_q;
  end

  // Priority pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri_q <= 1'b0;
    end else begin
      pri_q <= pri_d;
    end
  end

  assign ram_we = h_gnt | p_gnt;
  assign ram_wa = p_gnt ? p_addr : h_addr;
  assign ram_wd = p_gnt ? p_data : h_data;

  dpram u_dpram (
    .clk  (clk),
    .we_i (ram_we),
    .wa_i (ram_wa),
    .wd_i (ram_wd),
    .re_i (issue),
    .ra_i (addr_q),
    .rd_o (ram_rd)
  );

  // FIFO head and stream outputs
  assign head     = rd_ptr_q ? fifo1_q : fifo0_q;
  assign rd_valid = (cnt_q != 2'd0);
  assign rd_data  = head.data;
  assign rd_last  = rd_valid & head.last;
  assign rd_busy  = (state_q != ST_IDLE);
  assign pop      = rd_valid & rd_ready;
  assign push     = infl_q;

  // Issue only while buffered plus in-flight words leave room, treating a pop as a free slot
  always_comb begin
    occ        = cnt_q + {1'b0, infl_q} - {1'b0, pop};
    issue      = (state_q == ST_RUN) && (occ < 2'd2);
    issue_last = (remain_q == REMAIN_ONE);
  end

  // Sequencer next state: load on start, count issues, drain until the last word leaves
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_start) begin
          addr_d   = rd_base;
          remain_d = (rd_len == '0) ? BURST_MAX : {1'b0, rd_len};
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (issue_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && head.last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer registers and the one-deep in-flight tracker covering RAM read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      infl_q      <= issue;
      infl_last_q <= issue & issue_last;
    end
  end

  // Two-slot output buffer capturing RAM data one edge after issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo0_q  <= '0;
      fifo1_q  <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr_q) begin
          fifo1_q <= '{last: infl_last_q, data: ram_rd};
        end else begin
          fifo0_q <= '{last: infl_last_q, data: ram_rd};
        end
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_dpram_sched.sv
// tb/tb_dpram_sched.sv - directed self-checking bench for dpram_sched
module tb_dpram_sched;

  logic        clk;
  logic        rst;
  logic        h_req;
  logic [5:0]  h_addr;
  logic [7:0]  h_data;
  logic        h_gnt;
  logic        p_req;
  logic [5:0]  p_addr;
  logic [7:0]  p_data;
  logic        p_gnt;
  logic        rd_start;
  logic [4:0]  rd_base;
  logic [4:0]  rd_len;
  logic        rd_busy;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        rd_last;

  int          checks;
  int          errors;
  logic [7:0]  mem_m [64];

  dpram_sched dut (
    .clk      (clk),
    .rst      (rst),
    .h_req    (h_req),
    .h_addr   (h_addr),
    .h_data   (h_data),
    .h_gnt    (h_gnt),
    .p_req    (p_req),
    .p_addr   (p_addr),
    .p_data   (p_data),
    .p_gnt    (p_gnt),
    .rd_start (rd_start),
    .rd_base  (rd_base),
    .rd_len   (rd_len),
    .rd_busy  (rd_busy),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_last  (rd_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr_host(input logic [5:0] a, input logic [7:0] d);
    h_req = 1'b1; h_addr = a; h_data = d;
    #1;
    checks++;
    if (h_gnt !== 1'b1 || p_gnt !== 1'b0) begin
      errors++;
      $display("FAIL host_gnt addr=%0d got h=%b p=%b want h=1 p=0", a, h_gnt, p_gnt);
    end
    @(posedge clk); #1;
    h_req = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic wr_peri(input logic [5:0] a, input logic [7:0] d);
    p_req = 1'b1; p_addr = a; p_data = d;
    #1;
    checks++;
    if (p_gnt !== 1'b1 || h_gnt !== 1'b0) begin
      errors++;
      $display("FAIL peri_gnt addr=%0d got h=%b p=%b want h=0 p=1", a, h_gnt, p_gnt);
    end
    @(posedge clk); #1;
    p_req = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic run_burst(input logic [4:0] base, input logic [4:0] len, input int n,
                           input bit rand_ready, input bit check_timing, input bit inject);
    int          idx;
    int          cyc;
    int          first_cyc;
    int          last_cyc;
    logic [4:0]  wa;
    logic [15:0] exp_w;
    logic        exp_last;
    idx = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
    rd_base = base; rd_len = len; rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    while (idx < n && cyc < 400) begin
      rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_start = inject && (cyc == 3);
      rd_base  = inject ? 5'd0 : base;
      #1;
      checks++;
      if (rd_busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_in_burst cyc=%0d got %b want 1", cyc, rd_busy);
      end
      if (rd_valid === 1'b1 && first_cyc < 0) first_cyc = cyc;
      if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
        wa       = base + 5'(idx);
        exp_w    = {mem_m[{wa, 1'b1}], mem_m[{wa, 1'b0}]};
        exp_last = (idx == n - 1);
        checks++;
        if (rd_data !== exp_w || rd_last !== exp_last) begin
          errors++;
          $display("FAIL burst_word idx=%0d got data=%h last=%b want data=%h last=%b",
                   idx, rd_data, rd_last, exp_w, exp_last);
        end
        idx++;
        if (idx == n) last_cyc = cyc + 1;
      end
      @(posedge clk); #1;
      rd_start = 1'b0;
      cyc++;
    end
    rd_ready = 1'b0;
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL burst_count got %0d words want %0d", idx, n);
    end
    if (check_timing) begin
      checks++;
      if (first_cyc != 2) begin
        errors++;
        $display("FAIL first_valid_latency got %0d want 2", first_cyc);
      end
      checks++;
      if (last_cyc != n + 2) begin
        errors++;
        $display("FAIL last_transfer_cycle got %0d want %0d", last_cyc, n + 2);
      end
    end
    checks++;
    if (rd_busy !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_burst_idle got busy=%b valid=%b want 0 0", rd_busy, rd_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    h_req = 1'b0; h_addr = '0; h_data = '0;
    p_req = 1'b0; p_addr = '0; p_data = '0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0; rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({h_gnt, p_gnt, rd_valid, rd_last, rd_busy} !== 5'b0 || rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b%b v=%b l=%b b=%b d=%h want all 0",
               h_gnt, p_gnt, rd_valid, rd_last, rd_busy, rd_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_host_write();
    wr_host(6'd0, 8'h05);
    wr_host(6'd1, 8'h06);
    run_burst(5'd0, 5'd1, 1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_arbitration();
    logic [1:0] want [4];
    want[0] = 2'b10; want[1] = 2'b01; want[2] = 2'b10; want[3] = 2'b01;
    h_req = 1'b1; h_addr = 6'd2; h_data = 8'h11;
    p_req = 1'b1; p_addr = 6'd3; p_data = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({h_gnt, p_gnt} !== want[i]) begin
        errors++;
        $display("FAIL arb_alternate cyc=%0d got %b want %b", i, {h_gnt, p_gnt}, want[i]);
      end
      @(posedge clk); #1;
    end
    h_req = 1'b0; p_req = 1'b0;
    mem_m[2] = 8'h11;
    mem_m[3] = 8'h22;
  endtask

  task automatic fill_memory();
    for (int b = 4; b < 64; b++) begin
      if ((b & 1) != 0) wr_peri(6'(b), 8'(b * 7 + 3));
      else              wr_host(6'(b), 8'(b * 7 + 3));
    end
  endtask

  task automatic test_wrap();
    run_burst(5'd30, 5'd4, 4, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_len_zero();
    run_burst(5'd7, 5'd0, 32, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    run_burst(5'd20, 5'd16, 16, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    h_req = 1'b1; h_addr = 6'd2; h_data = mem_m[2];
    p_req = 1'b1; p_addr = 6'd3; p_data = mem_m[3];
    @(posedge clk); #1;
    h_req = 1'b0; p_req = 1'b0;
    rd_base = 5'd0; rd_len = 5'd8; rd_start = 1'b1; rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (rd_valid !== 1'b1 || rd_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_active got valid=%b busy=%b want 1 1", rd_valid, rd_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || rd_busy !== 1'b0 || rd_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort got valid=%b busy=%b last=%b want 0 0 0", rd_valid, rd_busy, rd_last);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rd_valid !== 1'b0 || rd_busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet cyc=%0d got valid=%b busy=%b want 0 0", i, rd_valid, rd_busy);
      end
    end
    rd_ready = 1'b0;
    h_req = 1'b1; p_req = 1'b1;
    #1;
    checks++;
    if ({h_gnt, p_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL pri_after_reset got %b want 10", {h_gnt, p_gnt});
    end
    h_req = 1'b0; p_req = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_host_write();
    test_arbitration();
    fill_memory();
    test_wrap();
    test_len_zero();
    test_backpressure();
    run_burst(5'd0, 5'd4, 4, 1'b0, 1'b1, 1'b0);
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
